alu_issue_seq: RTL
==================

# alu_issue_seq

Sequencing stage that sits directly upstream and downstream of the 32-bit ALU. It accepts one register-to-register or register-immediate operation per handshake and reads its operands from an internal register file. It drives the ALU's `opA`/`opB`/`sel` inputs from registers, then captures `res` into the destination register and `z`/`c`/`v` into a status register. The ALU is instantiated alongside this block, not inside it; the connection is through the `alu_*` ports.

## Interface

Parameters:
- `DATA_W`, 32, datapath width; must match the ALU.
- `NREGS`, 8, register count (`AW` = log2(NREGS) = 3).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept an operation.
- `in_sel` in 3: ALU operation code, passed to the ALU unchanged.
- `in_rd`, `in_rs1`, `in_rs2` in AW: destination and source register indices.
- `in_imm_en` in 1: when 1, `opB` comes from `in_imm` instead of `rs2`.
- `in_imm` in DATA_W: immediate operand.
- `alu_opA`, `alu_opB` out DATA_W: registered ALU operands.
- `alu_sel` out 3: registered ALU select.
- `alu_res` in DATA_W: ALU result (combinational from the ALU).
- `alu_z`, `alu_c`, `alu_v` in 1: ALU flags.
- `flag_z`, `flag_c`, `flag_v` out 1: status register.
- `wb_valid` out 1: one-cycle pulse; a writeback completed on the previous edge.
- `wb_rd` out AW: destination index of that writeback.
- `wb_data` out DATA_W: value written.
- `dbg_addr` in AW: debug read index.
- `dbg_data` out DATA_W: combinational read of `regs[dbg_addr]`.

## Operation

- Register file: `NREGS` × `DATA_W` flops. `r0` is hardwired to 0: writes to it are discarded and reads return 0.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - `in_ready` = 1.
  - When `in_valid`, on the next edge:
    - `alu_opA` ← `regs[in_rs1]`.
    - `alu_opB` ← `in_imm_en ? in_imm : regs[in_rs2]`.
    - `alu_sel` ← `in_sel`.
    - `rd_q` ← `in_rd`.
    - Go to EXEC.
- EXEC:
  - `in_ready` = 0. ALU inputs are stable for the whole cycle.
  - On the edge:
    - `regs[rd_q]` ← `alu_res` (suppressed if `rd_q` = 0).
    - `{flag_z, flag_c, flag_v}` ← `{alu_z, alu_c, alu_v}`. Flags update even when `rd_q` = 0, so r0 can be used as a compare destination.
    - `wb_rd` ← `rd_q`.
    - `wb_data` ← `alu_res` (the raw result, even when `rd_q` = 0).
    - Go to WB.
- WB:
  - `in_ready` = 0, `wb_valid` = 1.
  - Next edge returns to IDLE.
- `in_valid` asserted while `in_ready` = 0 is ignored. The requester must hold the request until the handshake completes.
- Register reads in IDLE see every prior writeback, because the write happens two edges before the next IDLE. No forwarding is needed.
- `alu_opA`/`alu_opB`/`alu_sel` hold their last values in WB and IDLE.
- Arithmetic, overflow and flag semantics belong entirely to the ALU. This block only transports values at full `DATA_W` width, with no extension or truncation.
- Reset asserted in any state:
  - FSM → IDLE.
  - All registers, `alu_opA`, `alu_opB`, `alu_sel` → 0.
  - Flags → 0, `wb_valid` → 0, `wb_rd` → 0, `wb_data` → 0.
  - An operation in flight is abandoned with no writeback.

## Timing

- Handshake at edge N (IDLE, `in_valid` = 1).
- ALU inputs valid in cycle N..N+1.
- Register and flag write at edge N+1.
- `wb_valid` high for cycle N+1..N+2.
- `in_ready` high again from edge N+2.
- Throughput: at most one operation every 3 cycles. Latency from handshake to visible register update: 2 edges.
- `in_ready` and `wb_valid` are decoded from registered state only, with no combinational path from `in_valid`.
- `dbg_data` reflects a writeback in the cycle after the writing edge.
- Values after reset release: `in_ready` = 1, `wb_valid` = 0, flags = 000, `dbg_data` = 0 for every address.

## Test plan

- Reset check: assert `rst` mid-cycle (asynchronous), then release. Required: `in_ready` = 1, `wb_valid` = 0, flags = 0, `dbg_data` = 0 for addresses 0–7.
- Immediate add then register add:
  - `sel` = 000 (add), `rs1` = r0, `imm_en` = 1, `imm` = 0x8FFFFFFF, `rd` = r1. Required: r1 = 0x8FFFFFFF.
  - Then add r1 + r1 → r2. Required: r2 = 0x1FFFFFFE, `flag_c` = 1, `flag_v` = 1.
  - `wb_valid` is exactly 1 cycle wide, 2 edges after each handshake.
- Compare into r0: `sel` = 001 (sub), r1 − r1, `rd` = r0. Required: r0 still reads 0, `flag_z` = 1, `wb_rd` = 0, `wb_data` = 0.
- Back-to-back requests: hold `in_valid` = 1 for three operations (r1 + imm 1 → r3, r3 + imm 1 → r3, r3 + imm 1 → r3). Required:
  - Handshakes and `wb_valid` pulses exactly 3 cycles apart.
  - Final r3 = 0x90000002, showing no hazard.
  - Changing the request fields while `in_ready` = 0 has no effect.
- Reset during EXEC: issue add imm 0x40000000 → r4, then assert `rst` in EXEC. Required: no `wb_valid`, r4 = 0, flags = 0, FSM back in IDLE.
- Debug port sweep: write distinct immediates 0x11…0x77 to r1–r7. Required: `dbg_addr` sweep returns each value, and address 0 returns 0.

Source files
------------

// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_seq
//  Description : Issue/writeback sequencer for an external 32-bit ALU.
//                Accepts one reg-reg or reg-imm operation per handshake,
//                reads operands from an internal register file, presents
//                registered operands/select to the ALU, then captures the
//                ALU result into the destination register and the ALU flags
//                into a status register. r0 reads as zero and ignores writes.
//
//  Ports:
//    clk, rst                  clock, asynchronous active-high reset
//    in_valid / in_ready       operation request handshake
//    in_sel                    ALU opcode (passed through unchanged)
//    in_rd, in_rs1, in_rs2     destination / source register indices
//    in_imm_en, in_imm         immediate select and value for operand B
//    alu_opA, alu_opB, alu_sel registered ALU inputs
//    alu_res, alu_z/c/v        ALU result and flags (combinational)
//    flag_z, flag_c, flag_v    status register
//    wb_valid, wb_rd, wb_data  one-cycle writeback report
//    dbg_addr, dbg_data        combinational register file read port
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_seq #(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 8,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic              in_imm_en,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_opA,
    output logic [DATA_W-1:0] alu_opB,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_rd_q;
    logic [DATA_W-1:0]   r_alu_opa;
    logic [DATA_W-1:0]   r_alu_opb;
    logic [2:0]          r_alu_sel;
    logic                r_flag_z;
    logic                r_flag_c;
    logic                r_flag_v;
    logic [AW-1:0]       r_wb_rd;
    logic [DATA_W-1:0]   r_wb_data;

    // Physical storage exists only for r1..r(NREGS-1); r0 is a constant zero.
    logic [DATA_W-1:0]   r_regs [1:NREGS-1];
    logic [DATA_W-1:0]   w_rf   [NREGS];

    assign w_rf[0] = '0;
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_rf
        assign w_rf[gi] = r_regs[gi];
    end

    // Handshake and writeback strobes come from state only, so there is
    // no combinational path from in_valid to in_ready.
    assign in_ready = (r_state == ST_IDLE);
    assign wb_valid = (r_state == ST_WB);

    assign alu_opA  = r_alu_opa;
    assign alu_opB  = r_alu_opb;
    assign alu_sel  = r_alu_sel;
    assign flag_z   = r_flag_z;
    assign flag_c   = r_flag_c;
    assign flag_v   = r_flag_v;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign dbg_data = w_rf[dbg_addr];

    // Sequencer: operand capture in IDLE, result/flag capture in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rd_q    <= '0;
            r_alu_opa <= '0;
            r_alu_opb <= '0;
            r_alu_sel <= '0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
            r_flag_v  <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_alu_opa <= w_rf[in_rs1];
                        r_alu_opb <= in_imm_en ? in_imm : w_rf[in_rs2];
                        r_alu_sel <= in_sel;
                        r_rd_q    <= in_rd;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Flags and the raw result are reported even for rd = r0,
                    // which lets r0 act as a compare destination.
                    r_flag_z  <= alu_z;
                    r_flag_c  <= alu_c;
                    r_flag_v  <= alu_v;
                    r_wb_rd   <= r_rd_q;
                    r_wb_data <= alu_res;
                    r_state   <= ST_WB;
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file write. The write lands two edges before the next IDLE,
    // so operand reads never need forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == ST_EXEC) begin
            for (int i = 1; i < NREGS; i++) begin
                if (r_rd_q == AW'(i)) begin
                    r_regs[i] <= alu_res;
                end
            end
        end
    end

endmodule
`default_nettype wire
